// File: rtl/pes_piso_framer.sv
// Parallel-in, serial-out framer: start bit (0), WIDTH data bits LSB-first,
// STOP_BITS stop bits (1), each held CLKS_PER_BIT clocks; line idles high.
module pes_piso_framer #(
    parameter int WIDTH        = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int TICK_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_MAX = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
    localparam int BIT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic [1:0]        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              serial_q, serial_d;

    logic bit_end;
    logic last_stop;
    logic accept;

    assign bit_end   = (tick_q == TICK_LAST);
    // The final stop-bit cycle doubles as an accept slot so frames can abut.
    assign last_stop = (state_q == S_STOP) && (bit_q == STOP_LAST) && bit_end;
    assign in_ready  = (state_q == S_IDLE) || last_stop;
    assign accept    = in_valid && in_ready;

    assign frame_done = last_stop;
    assign bit_valid  = (state_q == S_DATA);
    assign busy       = (state_q != S_IDLE);
    assign serial_out = serial_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    tick_d  = '0;
                    bit_d   = '0;
                    shift_d = in_data;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tick_d  = '0;
                    bit_d   = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        state_d = S_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                if (bit_end) begin
                    tick_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (accept) begin
                            state_d = S_START;
                            shift_d = in_data;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
        endcase

        // The line level is a function of the next state so serial_out is a flop.
        case (state_d)
            S_START: serial_d = 1'b0;
            S_DATA:  serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset forces the idle-high line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
        end
    end

endmodule

// File: tb/tb_pes_piso_framer.sv
// Directed bench for pes_piso_framer: three instances cover the default,
// CLKS_PER_BIT=3 and STOP_BITS=2 configurations.
module tb_pes_piso_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;

    logic rdy1, so1, bv1, by1, fd1;
    logic rdy3, so3, bv3, by3, fd3;
    logic rdy2, so2, bv2, by2, fd2;

    int   sel;
    logic obs_rdy, obs_so, obs_bv, obs_by, obs_fd;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pes_piso_framer #(.WIDTH(8), .STOP_BITS(1), .CLKS_PER_BIT(1)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data),
        .in_valid(in_valid && sel == 0), .in_ready(rdy1), .serial_out(so1),
        .bit_valid(bv1), .busy(by1), .frame_done(fd1)
    );

    pes_piso_framer #(.WIDTH(8), .STOP_BITS(1), .CLKS_PER_BIT(3)) u_dut_cpb3 (
        .clk(clk), .reset(reset), .in_data(in_data),
        .in_valid(in_valid && sel == 1), .in_ready(rdy3), .serial_out(so3),
        .bit_valid(bv3), .busy(by3), .frame_done(fd3)
    );

    pes_piso_framer #(.WIDTH(8), .STOP_BITS(2), .CLKS_PER_BIT(1)) u_dut_stop2 (
        .clk(clk), .reset(reset), .in_data(in_data),
        .in_valid(in_valid && sel == 2), .in_ready(rdy2), .serial_out(so2),
        .bit_valid(bv2), .busy(by2), .frame_done(fd2)
    );

    always_comb begin
        obs_rdy = rdy1; obs_so = so1; obs_bv = bv1; obs_by = by1; obs_fd = fd1;
        if (sel == 1) begin
            obs_rdy = rdy3; obs_so = so3; obs_bv = bv3; obs_by = by3; obs_fd = fd3;
        end else if (sel == 2) begin
            obs_rdy = rdy2; obs_so = so2; obs_bv = bv2; obs_by = by2; obs_fd = fd2;
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic so, input logic bv,
                             input logic fd, input logic by, input logic rd);
        check({tag, " serial_out"}, obs_so,  so);
        check({tag, " bit_valid"},  obs_bv,  bv);
        check({tag, " frame_done"}, obs_fd,  fd);
        check({tag, " busy"},       obs_by,  by);
        check({tag, " in_ready"},   obs_rdy, rd);
    endtask

    // Each character is one clock cycle; cycle 1 is the cycle after the first edge.
    // vld gives in_valid applied in that cycle; in_data switches to data_after after edge 1.
    task automatic run_seq(input string tag, input string vld, input logic [7:0] data_after,
                           input string so, input string bv, input string fd,
                           input string by, input string rd);
        for (int i = 0; i < so.len(); i++) begin
            @(posedge clk);
            #1;
            in_valid = (vld[i] == "1");
            if (i == 0) in_data = data_after;
            check_all($sformatf("%s c%0d", tag, i + 1), so[i] == "1", bv[i] == "1",
                      fd[i] == "1", by[i] == "1", rd[i] == "1");
        end
    endtask

    initial begin
        sel      = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2;
        check_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle line for 20 cycles.
        run_seq("idle", "00000000000000000000", 8'h00,
                "11111111111111111111", "00000000000000000000",
                "00000000000000000000", "00000000000000000000",
                "11111111111111111111");

        // Single frame 8'hA5, then idle.
        in_data = 8'hA5; in_valid = 1'b1;
        run_seq("a5", "000000000000", 8'h00,
                "010100101111", "011111111000", "000000000100",
                "111111111100", "000000000111");

        // Back-to-back 8'h3C then 8'hFF with in_valid held until the second accept.
        in_data = 8'h3C; in_valid = 1'b1;
        run_seq("b2b", {"1111111111", "0000000000", "00"}, 8'hFF,
                {"0001111001", "0111111111", "11"},
                {"0111111110", "0111111110", "00"},
                {"0000000001", "0000000001", "00"},
                {"1111111111", "1111111111", "00"},
                {"0000000001", "0000000001", "11"});

        // CLKS_PER_BIT=3, word 8'h01.
        sel = 1;
        in_data = 8'h01; in_valid = 1'b1;
        run_seq("cpb3", {"000", "000", "0000000", "0000000", "0000000", "000", "00"}, 8'h00,
                {"000", "111", "0000000", "0000000", "0000000", "111", "11"},
                {"000", "111", "1111111", "1111111", "1111111", "000", "00"},
                {"000", "000", "0000000", "0000000", "0000000", "001", "00"},
                {"111", "111", "1111111", "1111111", "1111111", "111", "00"},
                {"000", "000", "0000000", "0000000", "0000000", "001", "11"});

        // STOP_BITS=2, word 8'h80.
        sel = 2;
        in_data = 8'h80; in_valid = 1'b1;
        run_seq("stop2", "0000000000000", 8'h00,
                "0000000011111", "0111111110000", "0000000000100",
                "1111111111100", "0000000000111");

        // Async reset in the middle of the data bits of 8'h00.
        sel = 0;
        in_data = 8'h00; in_valid = 1'b1;
        run_seq("pre_rst", "0000", 8'h00, "0000", "0111", "0000", "1111", "0000");
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("rst_hold c%0d", i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        reset = 1'b0;

        in_data = 8'hA5; in_valid = 1'b1;
        run_seq("post_rst_a5", "000000000000", 8'h00,
                "010100101111", "011111111000", "000000000100",
                "111111111100", "000000000111");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
